// File: rtl/fx2_slave_fifo_responder.sv
// Behavioural stand-in for the FX2 slave-FIFO interface: EP2 OUT (host->FPGA) and
// EP6 IN (FPGA->host) with packet commit, driven by the FPGA master's strobes.
module fx2_slave_fifo_responder #(
  parameter int DATA_W    = 16,
  parameter int EP2_DEPTH = 512,
  parameter int EP6_DEPTH = 512,
  parameter int PKT_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              slwr,
  input  logic              slrd,
  input  logic              sloe,
  input  logic              pktend,
  input  logic [1:0]        fifo_addr,
  inout  wire  [DATA_W-1:0] usb_data,
  output logic              flag_a,
  output logic              flag_d,
  input  logic              h_wr_valid,
  input  logic [DATA_W-1:0] h_wr_data,
  output logic              h_wr_ready,
  output logic              h_rd_valid,
  output logic [DATA_W-1:0] h_rd_data,
  output logic              h_rd_last,
  input  logic              h_rd_ready,
  output logic              err_ovf,
  output logic              err_unf
);
  localparam int A2 = $clog2(EP2_DEPTH);
  localparam int A6 = $clog2(EP6_DEPTH);
  localparam int PW = $clog2(PKT_WORDS) + 1;
  localparam logic [PW-1:0] PKT_LAST = PW'(PKT_WORDS - 1);
  localparam logic [1:0] ADDR_EP2 = 2'b00;
  localparam logic [1:0] ADDR_EP6 = 2'b10;

  // ---------------- EP2: host pushes, master pops (FWFT) ----------------
  logic [DATA_W-1:0] ep2_mem [EP2_DEPTH];
  logic [A2:0]       ep2_wp, ep2_rp;
  logic              ep2_empty, ep2_full, ep2_sel, ep2_pop, ep2_push;
  logic [DATA_W-1:0] ep2_head;

  assign ep2_empty  = (ep2_wp == ep2_rp);
  assign ep2_full   = (ep2_wp[A2] != ep2_rp[A2]) && (ep2_wp[A2-1:0] == ep2_rp[A2-1:0]);
  assign ep2_sel    = (fifo_addr == ADDR_EP2);
  assign ep2_pop    = !slrd && ep2_sel && !ep2_empty;
  assign ep2_push   = h_wr_valid && !ep2_full;
  assign ep2_head   = ep2_mem[ep2_rp[A2-1:0]];
  assign flag_a     = !ep2_empty;
  assign h_wr_ready = !ep2_full;

  // Bus is only ever driven for an EP2 read; EP6 writes leave it to the master.
  assign usb_data = (!sloe && ep2_sel) ? (ep2_empty ? '0 : ep2_head) : 'z;

  always_ff @(posedge clk)
    if (ep2_push) ep2_mem[ep2_wp[A2-1:0]] <= h_wr_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ep2_wp  <= '0;
      ep2_rp  <= '0;
      err_unf <= 1'b0;
    end else begin
      if (ep2_push) ep2_wp <= ep2_wp + 1'b1;
      if (ep2_pop)  ep2_rp <= ep2_rp + 1'b1;
      if (!slrd && ep2_sel && ep2_empty) err_unf <= 1'b1;
    end
  end

  // ---------------- EP6: master writes, host drains committed packets ----------------
  logic [DATA_W-1:0] ep6_mem  [EP6_DEPTH];
  logic              ep6_last [EP6_DEPTH];
  logic [A6:0]       ep6_wp, ep6_cp, ep6_rp, wp_prev, rp_next;
  logic [PW-1:0]     pkt_cnt;
  logic              ep6_full, ep6_sel, ep6_wr, ep6_ovf, wr_last, pe_commit, host_pop;
  logic [DATA_W-1:0] head_data;
  logic              head_last;

  assign ep6_full   = (ep6_wp[A6] != ep6_rp[A6]) && (ep6_wp[A6-1:0] == ep6_rp[A6-1:0]);
  assign ep6_sel    = (fifo_addr == ADDR_EP6);
  assign ep6_wr     = !slwr && ep6_sel && !ep6_full;
  assign ep6_ovf    = !slwr && ep6_sel && ep6_full;
  assign wr_last    = (pkt_cnt == PKT_LAST) || !pktend;
  assign pe_commit  = !pktend && !ep6_wr && (pkt_cnt != '0);
  assign wp_prev    = ep6_wp - 1'b1;
  assign flag_d     = !ep6_full;
  assign h_rd_valid = (ep6_rp != ep6_cp);
  assign host_pop   = h_rd_valid && h_rd_ready;
  assign rp_next    = ep6_rp + (A6+1)'(host_pop);
  assign h_rd_data  = head_data;
  assign h_rd_last  = head_last && h_rd_valid;

  always_ff @(posedge clk)
    if (ep6_wr) ep6_mem[ep6_wp[A6-1:0]] <= usb_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < EP6_DEPTH; i++) ep6_last[i] <= 1'b0;
    end else if (ep6_wr) begin
      ep6_last[ep6_wp[A6-1:0]] <= wr_last;
    end else if (pe_commit) begin
      ep6_last[wp_prev[A6-1:0]] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ep6_wp  <= '0;
      ep6_cp  <= '0;
      ep6_rp  <= '0;
      pkt_cnt <= '0;
      err_ovf <= 1'b0;
    end else begin
      if (ep6_wr) begin
        ep6_wp <= ep6_wp + 1'b1;
        if (wr_last) begin
          ep6_cp  <= ep6_wp + 1'b1;
          pkt_cnt <= '0;
        end else begin
          pkt_cnt <= pkt_cnt + 1'b1;
        end
      end else if (pe_commit) begin
        ep6_cp  <= ep6_wp;
        pkt_cnt <= '0;
      end
      if (host_pop) ep6_rp <= rp_next;
      if (ep6_ovf)  err_ovf <= 1'b1;
    end
  end

  // Head register reloads every cycle; bypass covers a word (or its last bit)
  // landing on the new head slot at the same edge it becomes visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_data <= '0;
      head_last <= 1'b0;
    end else if (ep6_wr && (ep6_wp[A6-1:0] == rp_next[A6-1:0])) begin
      head_data <= usb_data;
      head_last <= wr_last;
    end else begin
      head_data <= ep6_mem[rp_next[A6-1:0]];
      head_last <= ep6_last[rp_next[A6-1:0]] ||
                   (pe_commit && (wp_prev[A6-1:0] == rp_next[A6-1:0]));
    end
  end
endmodule
